// File: rtl/sdram_port_arbiter_pkg.sv
// rtl/sdram_port_arbiter_pkg.sv - shared state encoding and default widths for the SDRAM port arbiter
package sdram_port_arbiter_pkg;

   localparam int DEF_ADDR_W = 24;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } arb_state_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - requester and controller side signals of the SDRAM port arbiter
interface sdram_port_arbiter_if
   import sdram_port_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W
);
   logic [NUM_PORTS-1:0]        port_req;
   logic [NUM_PORTS-1:0]        port_we;
   logic [NUM_PORTS*ADDR_W-1:0] port_addr;
   logic [NUM_PORTS*DATA_W-1:0] port_wdata;
   logic [NUM_PORTS-1:0]        port_ack;
   logic [NUM_PORTS-1:0]        port_rvalid;
   logic [DATA_W-1:0]           port_rdata;
   logic                        ctrl_req;
   logic                        ctrl_we;
   logic [ADDR_W-1:0]           ctrl_addr;
   logic [DATA_W-1:0]           ctrl_wdata;
   logic                        ctrl_ready;
   logic                        ctrl_rvalid;
   logic [DATA_W-1:0]           ctrl_rdata;
   logic                        busy;
   logic                        rd_timeout_err;

   // arbiter view
   modport slave (
      input  port_req, port_we, port_addr, port_wdata,
      input  ctrl_ready, ctrl_rvalid, ctrl_rdata,
      output port_ack, port_rvalid, port_rdata,
      output ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata,
      output busy, rd_timeout_err
   );

   // requesters plus controller view
   modport master (
      output port_req, port_we, port_addr, port_wdata,
      output ctrl_ready, ctrl_rvalid, ctrl_rdata,
      input  port_ack, port_rvalid, port_rdata,
      input  ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata,
      input  busy, rd_timeout_err
   );

endinterface

// File: rtl/sdram_port_arbiter_rr_picker.sv
// rtl/sdram_port_arbiter_rr_picker.sv - combinational round-robin select of one requesting port
module rr_picker #(
   parameter int NUM_PORTS = 2,
   parameter int PTR_W     = 1
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PTR_W-1:0]     rr_ptr,
   output logic [PTR_W-1:0]     grant_idx,
   output logic                 any_req
);

   logic           found;
   logic [PTR_W:0] sum;

   // Scan upward from rr_ptr with wrap-around; the first set request wins
   always_comb begin
      found     = 1'b0;
      sum       = '0;
      grant_idx = rr_ptr;
      any_req   = |req;
      for (int k = 0; k < NUM_PORTS; k++) begin
         sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NUM_PORTS)) begin
            sum = sum - (PTR_W+1)'(NUM_PORTS);
         end
         if (!found && req[sum[PTR_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = sum[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin sharing of one SDRAM controller between requester ports
module sdram_port_arbiter
   import sdram_port_arbiter_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_TIMEOUT = 64
) (
   input logic                 CLOCK_100,
   input logic                 rst_n,
   sdram_port_arbiter_if.slave bus
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CNT_W = $clog2(RD_TIMEOUT) + 1;

   arb_state_t state, state_nxt;

   logic [PTR_W-1:0]     rr_ptr, grant, pick_idx, grant_inc;
   logic                 any_req, accept, rd_done, rd_abort;
   logic [CNT_W-1:0]     timeout_cnt;
   logic                 ctrl_req_q, ctrl_we_q, rd_timeout_err_q;
   logic [ADDR_W-1:0]    ctrl_addr_q;
   logic [DATA_W-1:0]    ctrl_wdata_q, port_rdata_q;
   logic [NUM_PORTS-1:0] port_rvalid_q;

   rr_picker #(
      .NUM_PORTS (NUM_PORTS),
      .PTR_W     (PTR_W)
   ) u_picker (
      .req       (bus.port_req),
      .rr_ptr    (rr_ptr),
      .grant_idx (pick_idx),
      .any_req   (any_req)
   );

   assign accept    = (state == ISSUE) && ctrl_req_q && bus.ctrl_ready;
   assign rd_done   = (state == WAIT_RD) && bus.ctrl_rvalid;
   assign rd_abort  = (state == WAIT_RD) && !bus.ctrl_rvalid
                      && (timeout_cnt == CNT_W'(RD_TIMEOUT - 1));
   assign grant_inc = (grant == PTR_W'(NUM_PORTS - 1)) ? '0 : grant + PTR_W'(1);

   // Ack is the only combinational output: it marks the controller accept cycle
   assign bus.port_ack       = accept ? (NUM_PORTS'(1) << grant) : '0;
   assign bus.port_rvalid    = port_rvalid_q;
   assign bus.port_rdata     = port_rdata_q;
   assign bus.ctrl_req       = ctrl_req_q;
   assign bus.ctrl_we        = ctrl_we_q;
   assign bus.ctrl_addr      = ctrl_addr_q;
   assign bus.ctrl_wdata     = ctrl_wdata_q;
   assign bus.busy           = (state != IDLE);
   assign bus.rd_timeout_err = rd_timeout_err_q;

   // State register
   always_ff @(posedge CLOCK_100 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: one outstanding transaction, writes finish on accept, reads on data or timeout
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   if (accept) state_nxt = ctrl_we_q ? IDLE : WAIT_RD;
         WAIT_RD: if (rd_done || rd_abort) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command latch, round-robin pointer, read return routing and timeout tracking
   always_ff @(posedge CLOCK_100 or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr           <= '0;
         grant            <= '0;
         ctrl_req_q       <= 1'b0;
         ctrl_we_q        <= 1'b0;
         ctrl_addr_q      <= '0;
         ctrl_wdata_q     <= '0;
         port_rvalid_q    <= '0;
         port_rdata_q     <= '0;
         rd_timeout_err_q <= 1'b0;
         timeout_cnt      <= '0;
      end else begin
         port_rvalid_q <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant        <= pick_idx;
                  ctrl_req_q   <= 1'b1;
                  ctrl_we_q    <= bus.port_we[pick_idx];
                  ctrl_addr_q  <= bus.port_addr[pick_idx*ADDR_W +: ADDR_W];
                  ctrl_wdata_q <= bus.port_wdata[pick_idx*DATA_W +: DATA_W];
               end
            end
            ISSUE: begin
               if (accept) begin
                  ctrl_req_q  <= 1'b0;
                  rr_ptr      <= grant_inc;
                  timeout_cnt <= '0;
               end
            end
            WAIT_RD: begin
               if (rd_done) begin
                  port_rdata_q  <= bus.ctrl_rdata;
                  port_rvalid_q <= NUM_PORTS'(1) << grant;
               end else if (rd_abort) begin
                  rd_timeout_err_q <= 1'b1;
               end else if (timeout_cnt != '1) begin
                  timeout_cnt <= timeout_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares the single SDRAM controller (which drives DRAM_ADDR/BA/RAS_N/CAS_N/WE_N/DQ/DQM) between NUM_PORTS requesters, e.g. the button-driven test pattern writer and the LED readback logic in top.
- Round-robin grant; one outstanding transaction at a time.
- Read data is routed back to the owning port.
- Sits between the requesters and the controller in the CLOCK_100 domain.

Parameters:
NUM_PORTS, 2, number of requesting ports (2..4)
ADDR_W, 24, word address width (row/bank/column packed; the controller splits it)
DATA_W, 16, data width, matching DRAM_DQ
RD_TIMEOUT, 64, cycles to wait for ctrl_rvalid before aborting a read

Ports:
CLOCK_100  in  1  system clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
port_req  in  NUM_PORTS  per-port request; held with its fields until port_ack
port_we  in  NUM_PORTS  1 = write, 0 = read
port_addr  in  NUM_PORTS*ADDR_W  flattened; port i at [i*ADDR_W +: ADDR_W]
port_wdata  in  NUM_PORTS*DATA_W  flattened write data
port_ack  out  NUM_PORTS  one-hot; request accepted by the controller
port_rvalid  out  NUM_PORTS  one-hot, 1-cycle; read data valid for that port
port_rdata  out  DATA_W  shared read data bus; qualified by port_rvalid
ctrl_req  out  1  command valid to the controller
ctrl_we  out  1  latched write enable
ctrl_addr  out  ADDR_W  latched address
ctrl_wdata  out  DATA_W  latched write data
ctrl_ready  in  1  controller accepts the command this cycle
ctrl_rvalid  in  1  read data valid from the controller
ctrl_rdata  in  DATA_W  read data from the controller
busy  out  1  state != IDLE
rd_timeout_err  out  1  sticky; a read timed out

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; rr_ptr=0; grant=0.
  - All ctrl_* outputs = 0; port_rvalid = 0; port_rdata = 0; rd_timeout_err = 0; busy = 0.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any port_req is set, select the first requesting port searching upward from rr_ptr with wrap-around. Example with NUM_PORTS=2: rr_ptr=1, req=2'b11 -> port 1.
  - Latch that port's we/addr/wdata into the ctrl_* registers, set grant, set ctrl_req=1, go to ISSUE.
  - Request-to-ctrl_req latency: 1 cycle.
- ISSUE:
  - ctrl_req and the ctrl_* fields stay stable until ctrl_ready=1.
  - port_ack[grant] = ctrl_req & ctrl_ready. This is combinational, asserted in the accept cycle, and is the only combinational output.
  - On accept: ctrl_req=0 next cycle; rr_ptr = grant+1 (mod NUM_PORTS).
  - Write: go to IDLE. Read: go to WAIT_RD and clear timeout_cnt.
  - The requester drops or changes port_req the cycle after port_ack. Because the arbiter re-enters IDLE on that same edge, the same request is never issued twice.
- WAIT_RD:
  - On ctrl_rvalid: port_rdata <= ctrl_rdata and port_rvalid[grant] <= 1 for exactly one cycle (1-cycle registered latency); go to IDLE.
  - Otherwise timeout_cnt increments. When it reaches RD_TIMEOUT-1 without ctrl_rvalid: set rd_timeout_err, assert no port_rvalid, go to IDLE.
  - A ctrl_rvalid arriving after the abort is ignored.
- ctrl_rvalid outside WAIT_RD is ignored.
- Requests are not sampled in ISSUE or WAIT_RD. Other ports wait; their port_req must stay held.
- If port_req drops after latching (in ISSUE), the latched command still completes and is acked.
- A request dropped while waiting in IDLE is never issued.
- rd_timeout_err is cleared only by reset.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; the controller must tolerate an abandoned ctrl_req.
- timeout_cnt width: $clog2(RD_TIMEOUT)+1, saturating.

Decomposition:
- Shared package/header sdram_pkg.vh: state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT_RD=2'd2) and the default ADDR_W/DATA_W, reused by the controller.
- One sub-module, rr_picker: combinational round-robin select (req vector + rr_ptr -> grant index + any_req).

Test Plan:
- Single write: port0 req, we=1, addr=0x000123, wdata=0xBEEF; ctrl_ready held 1 -> ctrl_req high 1 cycle after req, port_ack=2'b01 in that cycle, ctrl_addr=0x000123, ctrl_wdata=0xBEEF, then IDLE.
- Read return: port1 read of addr 0x000123; ctrl_rvalid arrives 5 cycles after accept with 0xBEEF -> port_rvalid=2'b10 for 1 cycle, port_rdata=0xBEEF, busy falls the same cycle.
- Fairness: both ports request writes continuously, ctrl_ready always 1 -> grants alternate 0,1,0,1 over 8 transactions, with no repeat grant while the other port waits.
- Backpressure: ctrl_ready low for 4 cycles during ISSUE while port_req and addr change -> ctrl_addr and ctrl_req remain stable, ack occurs only on the ready cycle, and the latched address is the one issued.
- Timeout: read accepted, ctrl_rvalid never asserted -> after 64 cycles rd_timeout_err=1, no port_rvalid, next request served normally; a late ctrl_rvalid is ignored.
- Reset mid-read: rst_n pulsed low in WAIT_RD -> all outputs 0 asynchronously, rd_timeout_err=0, rr_ptr=0, first request after release goes to port 0.
